// File: rtl/mmm_a_serializer.sv
// mmm_a_serializer: parallel-load, LSB-first bit feeder for the Montgomery multiplier iteration loop
module mmm_a_serializer #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld_a,
  input  logic [WIDTH-1:0] a_i,
  output logic             a_bit_o,
  output logic             busy_o,
  output logic             last_o,
  output logic [CNT_W-1:0] iter_o,
  output logic             done_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] iter;
  logic load, at_last;
  assign load = en & ld_a;
  assign at_last = iter == CNT_W'(WIDTH - 1);
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  // a load wins from any state; DONE always falls through after one cycle
  always_comb
    state_nxt = load ? SHIFT : state == SHIFT ? ((en && at_last) ? DONE : SHIFT) : IDLE;
  // operand shifter and bit index; the index clears on load and on the final shift
  always_ff @(posedge clk)
    if (rst) begin
      sreg <= '0;
      iter <= '0;
    end else if (load) begin
      sreg <= a_i;
      iter <= '0;
    end else if (state == SHIFT && en) begin
      sreg <= sreg >> 1;
      iter <= at_last ? '0 : iter + 1'b1;
    end
  // outputs decoded from registered state; only a_bit_o depends on the shifter
  always_comb begin
    busy_o  = state == SHIFT;
    done_o  = state == DONE;
    a_bit_o = busy_o & sreg[0];
    last_o  = busy_o & at_last;
    iter_o  = iter;
  end
endmodule

// File: tb/tb_mmm_a_serializer.sv
// tb_mmm_a_serializer: directed and randomized checks against a bit-position reference model
module tb_mmm_a_serializer;
  localparam int W = 10;
  localparam int C = 4;
  logic clk = 0;
  logic rst = 1, en = 0, ld_a = 0;
  logic [W-1:0] a_i = '0;
  logic a_bit_o, busy_o, last_o, done_o;
  logic [C-1:0] iter_o;
  int total = 0, passed = 0;
  bit m_act = 0, m_done = 0;
  int m_pos = 0;
  logic [W-1:0] m_op = '0;
  logic [W-1:0] bits;
  int n;

  mmm_a_serializer #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .en(en), .ld_a(ld_a), .a_i(a_i),
    .a_bit_o(a_bit_o), .busy_o(busy_o), .last_o(last_o), .iter_o(iter_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_act = 0; m_pos = 0; m_done = 0;
    end else if (en && ld_a) begin
      m_act = 1; m_op = a_i; m_pos = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_act && en) begin
      m_pos++;
      if (m_pos == W) begin
        m_act = 0; m_pos = 0; m_done = 1;
      end
    end
    #1;
    check("busy", busy_o, m_act);
    check("a_bit", a_bit_o, m_act ? 32'((m_op >> m_pos) & 1) : 0);
    check("iter", iter_o, m_pos);
    check("last", last_o, m_act && m_pos == W - 1);
    check("done", done_o, m_done);
  endtask

  task automatic drive(input logic r, input logic e, input logic l, input logic [W-1:0] a);
    rst = r; en = e; ld_a = l; a_i = a;
    tick();
  endtask

  initial begin
    drive(1, 1, 1, 10'h2D5);
    drive(1, 1, 1, 10'h2D5);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    drive(0, 1, 1, 10'h2D5);
    check("load_after_rst", busy_o, 1);
    bits[0] = a_bit_o;
    for (int i = 1; i < W; i++) begin
      drive(0, 1, 0, 10'h000);
      bits[i] = a_bit_o;
      if (i == W - 1) check("last_bit10", {last_o, 28'(iter_o)}, {1'b1, 28'd9});
    end
    check("seq_2d5", bits, 10'h2D5);
    drive(0, 1, 0, 10'h000);
    check("done_cycle11", {done_o, busy_o}, 2'b10);
    drive(0, 1, 0, 10'h000);
    check("done_one_cycle", done_o, 0);

    drive(0, 1, 1, 10'h2D5);
    n = 0;
    for (int i = 0; i < 100 && !done_o; i++) drive(0, (i % 4 == 0) || (i % 4 == 3), 0, 10'h000);
    check("stall_done_seen", done_o, 1);

    drive(0, 1, 1, 10'h3FF);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 10'h000);
    drive(0, 1, 1, 10'h001);
    check("restart_iter", iter_o, 0);
    bits[0] = a_bit_o;
    for (int i = 1; i < W; i++) begin
      drive(0, 1, 0, 10'h000);
      bits[i] = a_bit_o;
    end
    check("seq_restart", bits, 10'h001);
    drive(0, 1, 0, 10'h000);
    check("restart_done", done_o, 1);

    drive(0, 1, 1, 10'h2D5);
    for (int i = 0; i < 30 && !done_o; i++) drive(0, 1, 0, 10'h000);
    check("b2b_done_seen", done_o, 1);
    drive(0, 1, 1, 10'h155);
    check("b2b_no_gap", busy_o, 1);
    bits[0] = a_bit_o;
    for (int i = 1; i < W; i++) begin
      drive(0, 1, 0, 10'h000);
      bits[i] = a_bit_o;
    end
    check("seq_155", bits, 10'h155);
    drive(0, 1, 0, 10'h000);

    drive(0, 1, 1, 10'h3FF);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 10'h000);
    check("mid_iter5", iter_o, 5);
    drive(1, 1, 0, 10'h000);
    check("mid_rst", {busy_o, a_bit_o, 28'(iter_o)}, 0);
    drive(0, 1, 0, 10'h000);
    check("mid_rst_nodone", done_o, 0);

    for (int i = 0; i < 2000; i++)
      drive($urandom_range(99) < 2, $urandom_range(99) < 70, $urandom_range(99) < 6, W'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
